// File: rtl/keypad_time_loader.sv
// keypad_time_loader: debounces keypad digits and shifts them into an MM:SS entry register.
// Optional LOADER_SEC_CLAMP_EN clamps displayed seconds above 59 to 59.
module keypad_time_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DBC_W           = 8
) (
    input  logic       clk,
    input  logic       clear_,
    input  logic       enable_,
    input  logic       flush_,
    input  logic [3:0] bcd_in,
    input  logic       data_valid,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] digits_entered,
    output logic       full,
    output logic       key_accepted
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;
    localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DEBOUNCE_CYCLES);
    logic [1:0]       state_q, state_d;
    logic [DBC_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dig_q, dig_d;
    logic [15:0]      tm_q, tm_d;
    logic [2:0]       num_q, num_d;
    logic             acc_q, acc_d;
    logic             do_acc;
    logic [3:0]       acc_dig;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        tm_d    = tm_q;
        num_d   = num_q;
        acc_d   = 1'b0;
        do_acc  = 1'b0;
        acc_dig = dig_q;
        if (!flush_) begin
            state_d = IDLE;
            cnt_d   = '0;
            tm_d    = '0;
            num_d   = '0;
        end else if (enable_) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (data_valid) begin
                    dig_d = bcd_in;
                    cnt_d = DBC_W'(1);
                    if (DEBOUNCE_CYCLES == 1) begin
                        do_acc  = 1'b1;
                        acc_dig = bcd_in;
                    end else state_d = DEBOUNCE;
                end
                DEBOUNCE: if (!data_valid || bcd_in != dig_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    do_acc = (cnt_d == DBC_MAX);
                end
                WAIT_RELEASE: state_d = data_valid ? WAIT_RELEASE : IDLE;
                default: state_d = IDLE;
            endcase
        end
        // Full or non-decimal keys still consume the press so a held key is not retried.
        if (do_acc) begin
            state_d = WAIT_RELEASE;
            if (acc_dig <= 4'd9 && !full) begin
                tm_d  = {tm_q[11:0], acc_dig};
                num_d = num_q + 3'd1;
                acc_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dig_q   <= '0;
            tm_q    <= '0;
            num_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            tm_q    <= tm_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
        end
    end
    assign min_tens       = tm_q[15:12];
    assign min_ones       = tm_q[11:8];
    assign digits_entered = num_q;
    assign full           = (num_q == 3'd4);
    assign key_accepted   = acc_q;
`ifdef LOADER_SEC_CLAMP_EN
    logic clamp;
    assign clamp    = tm_q[7:4] > 4'd5;
    assign sec_tens = clamp ? 4'd5 : tm_q[7:4];
    assign sec_ones = clamp ? 4'd9 : tm_q[3:0];
`else
    assign sec_tens = tm_q[7:4];
    assign sec_ones = tm_q[3:0];
`endif
endmodule

// File: tb/tb_keypad_time_loader.sv
// tb_keypad_time_loader: table-driven per-cycle vectors plus an async-clear sequence.
module tb_keypad_time_loader;
    logic       clk = 1'b0;
    logic       clear_ = 1'b0;
    logic       enable_ = 1'b0;
    logic       flush_ = 1'b1;
    logic [3:0] bcd_in = '0;
    logic       data_valid = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] digits_entered;
    logic       full, key_accepted;
    int         n_checks = 0;
    int         n_pass = 0;

`ifdef LOADER_SEC_CLAMP_EN
    localparam logic [15:0] EXP75 = 16'h0059;
`else
    localparam logic [15:0] EXP75 = 16'h0075;
`endif

    typedef struct {
        logic       fl;
        logic       en;
        logic       dv;
        logic [3:0] bcd;
        logic [15:0] tm;
        logic [2:0] cnt;
        logic       ka;
    } vec_t;
    vec_t vecs[$];

    keypad_time_loader #(.DEBOUNCE_CYCLES(4), .DBC_W(8)) dut (
        .clk(clk), .clear_(clear_), .enable_(enable_), .flush_(flush_),
        .bcd_in(bcd_in), .data_valid(data_valid),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .digits_entered(digits_entered), .full(full), .key_accepted(key_accepted)
    );

    always #5 clk = ~clk;

    function automatic void add(logic fl, logic en, logic dv, logic [3:0] bcd,
                                logic [15:0] tm, logic [2:0] cnt, logic ka);
        vec_t v;
        v.fl = fl; v.en = en; v.dv = dv; v.bcd = bcd; v.tm = tm; v.cnt = cnt; v.ka = ka;
        vecs.push_back(v);
    endfunction

    // acc = index of the held cycle that should accept (0 = never); gap idle cycles follow.
    function automatic void press(logic [3:0] bcd, int hold, int acc, logic [15:0] b_tm,
                                  logic [2:0] b_cnt, logic [15:0] a_tm, logic [2:0] a_cnt, int gap);
        for (int i = 1; i <= hold; i++)
            if (acc != 0 && i >= acc) add(1, 0, 1, bcd, a_tm, a_cnt, i == acc);
            else add(1, 0, 1, bcd, b_tm, b_cnt, 0);
        for (int i = 0; i < gap; i++) add(1, 0, 0, 4'd0, a_tm, a_cnt, 0);
    endfunction

    task automatic chk(input string name, input logic [15:0] tm, input logic [2:0] cnt, input logic ka);
        logic [23:0] got, exp;
        got = {min_tens, min_ones, sec_tens, sec_ones, 1'b0, digits_entered, 2'b0, full, key_accepted};
        exp = {tm, 1'b0, cnt, 2'b0, cnt == 3'd4, ka};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got time=%h cnt=%0d full=%0b ka=%0b, expected time=%h cnt=%0d full=%0b ka=%0b",
                      name, got[23:8], got[6:4], got[1], got[0], tm, cnt, cnt == 3'd4, ka);
    endtask

    initial begin
        // single key held 10 cycles
        press(4'd3, 10, 4, 16'h0000, 0, 16'h0003, 1, 2);
        // 1,3,0 -> 01:30
        add(0, 0, 0, 0, 16'h0000, 0, 0);
        press(4'd1, 6, 4, 16'h0000, 0, 16'h0001, 1, 2);
        press(4'd3, 6, 4, 16'h0001, 1, 16'h0013, 2, 2);
        press(4'd0, 6, 4, 16'h0013, 2, 16'h0130, 3, 2);
        // short glitch, then digit changing mid-press
        add(0, 0, 0, 0, 16'h0000, 0, 0);
        press(4'd5, 3, 0, 16'h0000, 0, 16'h0000, 0, 1);
        add(1, 0, 1, 4'd5, 16'h0000, 0, 0);
        press(4'd6, 7, 5, 16'h0000, 0, 16'h0006, 1, 1);
        // fill to 12:34 then an ignored fifth key
        add(0, 0, 0, 0, 16'h0000, 0, 0);
        press(4'd1, 5, 4, 16'h0000, 0, 16'h0001, 1, 1);
        press(4'd2, 5, 4, 16'h0001, 1, 16'h0012, 2, 1);
        press(4'd3, 5, 4, 16'h0012, 2, 16'h0123, 3, 1);
        press(4'd4, 5, 4, 16'h0123, 3, 16'h1234, 4, 1);
        press(4'd5, 6, 0, 16'h1234, 4, 16'h1234, 4, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 0);
        // non-decimal code is rejected
        press(4'd12, 6, 0, 16'h0000, 0, 16'h0000, 0, 1);
        // enable_ high blocks and restarts debounce
        repeat (3) add(1, 1, 1, 4'd8, 16'h0000, 0, 0);
        repeat (2) add(1, 0, 1, 4'd8, 16'h0000, 0, 0);
        add(1, 1, 1, 4'd8, 16'h0000, 0, 0);
        press(4'd8, 5, 4, 16'h0000, 0, 16'h0008, 1, 1);
        // flush on the accept edge wins; held key re-debounced afterwards
        press(4'd9, 3, 0, 16'h0008, 1, 16'h0008, 1, 0);
        add(0, 0, 1, 4'd9, 16'h0000, 0, 0);
        press(4'd9, 5, 4, 16'h0000, 0, 16'h0009, 1, 1);
        // 0,7,5 -> register 00:75
        add(0, 0, 0, 0, 16'h0000, 0, 0);
        press(4'd0, 5, 4, 16'h0000, 0, 16'h0000, 1, 1);
        press(4'd7, 5, 4, 16'h0000, 1, 16'h0007, 2, 1);
        press(4'd5, 5, 4, 16'h0007, 2, EXP75, 3, 1);

        repeat (2) @(posedge clk);
        #1 chk("reset", 16'h0000, 0, 0);
        @(negedge clk) clear_ = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            flush_ = vecs[i].fl; enable_ = vecs[i].en; data_valid = vecs[i].dv; bcd_in = vecs[i].bcd;
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), vecs[i].tm, vecs[i].cnt, vecs[i].ka);
        end

        // asynchronous clear mid-debounce with key 7 held
        @(negedge clk);
        flush_ = 1'b1; enable_ = 1'b0; data_valid = 1'b1; bcd_in = 4'd7;
        repeat (2) @(posedge clk);
        #2 clear_ = 1'b0;
        #1 chk("clear_async", 16'h0000, 0, 0);
        @(negedge clk) clear_ = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 chk($sformatf("post_clear%0d", i), 16'h0000, 0, 0);
        end
        @(posedge clk);
        #1 chk("post_clear_accept", 16'h0007, 1, 1);
        @(negedge clk) data_valid = 1'b0;
        @(posedge clk);
        #1 chk("post_clear_release", 16'h0007, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_time_loader.md
Name: keypad_time_loader

Overview:
- Consumes the keypad encoder's BCD digit and data_valid strobe, and debounces each key press.
- Shifts each accepted digit into a 4-digit MM:SS entry register, least-significant first, in the same way as a microwave keypad ("1","3","0" gives 01:30).
- Sits between the keypad encoder and the cook-time countdown. The controller gates entry with enable_ and clears the entry with flush_.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples of data_valid and bcd_in needed before a digit is accepted (must be >= 1)
DBC_W, 8, width of the debounce counter (2**DBC_W > DEBOUNCE_CYCLES)

Ports:
clk  input  1  system clock, rising edge
clear_  input  1  asynchronous active-low reset
enable_  input  1  active-low entry enable from the controller; high blocks all acceptance
flush_  input  1  synchronous active-low entry clear
bcd_in  input  4  BCD digit from the keypad encoder
data_valid  input  1  key-present strobe from the keypad encoder
min_tens  output  4  entered minutes, tens digit
min_ones  output  4  entered minutes, ones digit
sec_tens  output  4  entered seconds, tens digit
sec_ones  output  4  entered seconds, ones digit
digits_entered  output  3  number of digits accepted, 0..4
full  output  1  high when digits_entered == 4
key_accepted  output  1  one-cycle pulse on the edge a digit is shifted in

Behaviour:
- Reset (clear_ low, asynchronous):
  - all digit outputs 0, digits_entered 0, full 0, key_accepted 0;
  - FSM in IDLE, debounce counter 0, captured digit 0.
- The FSM has three states: IDLE, DEBOUNCE, WAIT_RELEASE. All registers update on the rising edge of clk.
- IDLE:
  - if enable_=0 and data_valid=1: capture bcd_in, set counter=1;
  - if DEBOUNCE_CYCLES==1, perform the accept action immediately; otherwise go to DEBOUNCE.
- DEBOUNCE:
  - if data_valid=0 or bcd_in differs from the captured digit: go to IDLE, counter=0, no accept;
  - else increment the counter; when the counter reaches DEBOUNCE_CYCLES, perform the accept action.
- Accept action, on the same edge:
  - if the captured digit <= 9 and full=0:
    - shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit;
    - digits_entered += 1; key_accepted=1 for exactly one cycle.
  - if the digit > 9 or full=1: no shift, no pulse.
  - In all cases go to WAIT_RELEASE.
- WAIT_RELEASE: stay until data_valid is sampled 0, then go to IDLE. A held key is therefore accepted once only; there is no auto-repeat.
- Latency: the digit appears on the outputs at the DEBOUNCE_CYCLES-th consecutive rising edge on which data_valid=1 and bcd_in is stable.
- enable_=1 in any state: FSM goes to IDLE on the next edge and the counter clears. Digits and count are retained, and no accept occurs on that edge.
- flush_=0 (synchronous, highest priority after reset):
  - digits 0, digits_entered 0, FSM to IDLE, counter 0, key_accepted 0;
  - overrides an accept on the same edge.
  - If a key is still held after flush_ is released, it is re-debounced from IDLE and accepted once.
- full is combinational: (digits_entered == 4). Once full, further keys are debounced but ignored; only flush_ or reset re-arms entry.
- Glitch rule: a data_valid pulse shorter than DEBOUNCE_CYCLES samples produces no key_accepted.

Optional Feature:
- Macro: LOADER_SEC_CLAMP_EN.
- Defined:
  - when the internal sec_tens register is > 5, outputs are sec_tens=5 and sec_ones=9 (combinational clamp);
  - the internal registers are unchanged, so later shifts use the raw digits.
- Undefined: sec_tens and sec_ones drive the raw register values (e.g. 07:75 is passed through).

Test Plan:
- DEBOUNCE_CYCLES=4, enable_=0: hold bcd_in=3 with data_valid=1 for 10 cycles, then release.
  - key_accepted pulses exactly once, on the 4th high sample; sec_ones=3, digits_entered=1.
- Keys 1,3,0, each held 6 cycles with 2 idle cycles between them.
  - Outputs read 01:30, i.e. min_tens=0, min_ones=1, sec_tens=3, sec_ones=0, digits_entered=3.
- data_valid high for 3 cycles (below threshold), then bcd_in changing from 5 to 6 at cycle 2 of a press held 5 cycles.
  - First press: no accept. Second press: re-debounced from IDLE, accepting 6 after 4 stable samples.
- Enter 1,2,3,4 (full=1), then key 5.
  - Outputs stay 12:34 and key_accepted stays 0.
  - flush_=0 for one cycle: all digits 0, digits_entered=0, full=0.
- clear_ asserted mid-DEBOUNCE with key 7 held: outputs go to 0 immediately.
  - After clear_ deasserts with the key still held: accept after 4 samples, sec_ones=7.
- With LOADER_SEC_CLAMP_EN defined, enter 0,7,5 (register 00:75).
  - Outputs read sec_tens=5, sec_ones=9.
  - Without the macro, outputs read sec_tens=7, sec_ones=5.
